scm_2ch_tcdm_ctrl: RTL

- Request-side controller directly upstream of the latch-based 3-read/2-write byte-enabled register file.
- Accepts two TCDM-style request channels (ch0, ch1) and maps them onto the register file's read ports A/B and write ports A/B.
- Resolves same-address write contention by round-robin grant, so the register file never sees colliding writes.
- Generates the 1-cycle read response (r_valid/r_rdata) and a saturating contention counter.

---
 rtl/scm_ctrl_pkg.sv | 24 ++
 rtl/scm_rr_arb2.sv | 27 ++
 rtl/scm_2ch_tcdm_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/scm_ctrl_pkg.sv
// Shared types for the 2-channel TCDM controller in front of the latch-based
// 3R/2W register file.
package scm_ctrl_pkg;

  localparam int NUM_CH      = 2;
  localparam int SCM_ADDR_W  = 5;
  localparam int SCM_DATA_W  = 32;
  localparam int SCM_NUM_BYTE = SCM_DATA_W / 8;

  typedef struct packed {
    logic                    req;
    logic                    we;
    logic [SCM_ADDR_W-1:0]   addr;
    logic [SCM_DATA_W-1:0]   wdata;
    logic [SCM_NUM_BYTE-1:0] be;
  } chan_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [SCM_DATA_W-1:0] rdata;
  } chan_rsp_t;

endpackage

// File: rtl/scm_rr_arb2.sv
// Two-way round-robin arbiter: passes requests through unless the two
// channels contend, then grants only the pointed-to channel and flips the pointer.
module scm_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       cont_i,
  output logic [1:0] gnt_o
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    gnt_o    = req_i;
    if (cont_i) begin
      gnt_o    = rr_ptr_q ? 2'b10 : 2'b01;
      rr_ptr_d = ~rr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 1'b0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/scm_2ch_tcdm_ctrl.sv
// Maps two TCDM channels onto the register file ports (ch0->A, ch1->B),
// arbitrates same-address writes and produces the 1-cycle read response.
module scm_2ch_tcdm_ctrl
  import scm_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CH-1:0]                 ch_req_i,
  output logic [NUM_CH-1:0]                 ch_gnt_o,
  input  logic [NUM_CH-1:0]                 ch_we_i,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] ch_addr_i,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_wdata_i,
  input  logic [NUM_CH-1:0][NUM_BYTE-1:0]   ch_be_i,
  output logic [NUM_CH-1:0]                 ch_rvalid_o,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_rdata_o,
  input  logic                              cnt_clr_i,
  output logic [CNT_WIDTH-1:0]              cont_cnt_o,
  output logic                              rf_re_a_o,
  output logic                              rf_re_b_o,
  output logic                              rf_re_c_o,
  output logic [ADDR_WIDTH-1:0]             rf_raddr_a_o,
  output logic [ADDR_WIDTH-1:0]             rf_raddr_b_o,
  output logic [ADDR_WIDTH-1:0]             rf_raddr_c_o,
  input  logic [DATA_WIDTH-1:0]             rf_rdata_a_i,
  input  logic [DATA_WIDTH-1:0]             rf_rdata_b_i,
  output logic                              rf_we_a_o,
  output logic                              rf_we_b_o,
  output logic [ADDR_WIDTH-1:0]             rf_waddr_a_o,
  output logic [ADDR_WIDTH-1:0]             rf_waddr_b_o,
  output logic [DATA_WIDTH-1:0]             rf_wdata_a_o,
  output logic [DATA_WIDTH-1:0]             rf_wdata_b_o,
  output logic [NUM_BYTE-1:0]               rf_wbe_a_o,
  output logic [NUM_BYTE-1:0]               rf_wbe_b_o
);

  chan_req_t                   req_s [NUM_CH];
  chan_rsp_t                   rsp_s [NUM_CH];
  logic [NUM_CH-1:0]           gnt;
  logic [NUM_CH-1:0]           rf_we, rf_re;
  logic [NUM_CH-1:0]           rvalid_q, rvalid_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] rf_rdata;
  logic                        cont;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;

  assign rf_rdata = {rf_rdata_b_i, rf_rdata_a_i};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign req_s[i] = '{req: ch_req_i[i], we: ch_we_i[i], addr: ch_addr_i[i],
                        wdata: ch_wdata_i[i], be: ch_be_i[i]};
    assign rf_we[i]    = gnt[i] & req_s[i].req & req_s[i].we;
    assign rf_re[i]    = gnt[i] & req_s[i].req & ~req_s[i].we;
    assign rvalid_d[i] = rf_re[i];
    // Read data comes straight from the register file, which holds the
    // captured word until the next read on that port.
    assign rsp_s[i] = '{gnt: gnt[i], rvalid: rvalid_q[i], rdata: rf_rdata[i]};
    assign ch_gnt_o[i]    = rsp_s[i].gnt;
    assign ch_rvalid_o[i] = rsp_s[i].rvalid;
    assign ch_rdata_o[i]  = rsp_s[i].rdata;
  end

  // Byte enables are ignored: any same-word double write is a conflict.
  assign cont = req_s[0].req & req_s[1].req & req_s[0].we & req_s[1].we &
                (req_s[0].addr == req_s[1].addr);

  scm_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (ch_req_i),
    .cont_i (cont),
    .gnt_o  (gnt)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)                 cnt_d = '0;
    else if (cont && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      cnt_q    <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cont_cnt_o = cnt_q;

  assign rf_re_a_o    = rf_re[0];
  assign rf_re_b_o    = rf_re[1];
  assign rf_re_c_o    = 1'b0;
  assign rf_raddr_a_o = req_s[0].addr;
  assign rf_raddr_b_o = req_s[1].addr;
  assign rf_raddr_c_o = '0;
  assign rf_we_a_o    = rf_we[0];
  assign rf_we_b_o    = rf_we[1];
  assign rf_waddr_a_o = req_s[0].addr;
  assign rf_waddr_b_o = req_s[1].addr;
  assign rf_wdata_a_o = req_s[0].wdata;
  assign rf_wdata_b_o = req_s[1].wdata;
  assign rf_wbe_a_o   = req_s[0].be;
  assign rf_wbe_b_o   = req_s[1].be;

`ifndef SYNTHESIS
  a_no_wcollide: assert property (@(posedge clk) disable iff (!rst_n)
    !(rf_we_a_o && rf_we_b_o && (rf_waddr_a_o == rf_waddr_b_o)));
`endif

endmodule
